// File: rtl/alu_bist.sv
// rtl/alu_bist.sv - RV32 ALU built-in self-test engine; define ALU_BIST_ERRLOG_EN to capture the first failing vector index.
module alu_bist #(
  parameter int NUM_VECTORS   = 10,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_count,
  output logic [3:0]  first_fail_idx,
  output logic [31:0] alu_src_a,
  output logic [31:0] alu_src_b,
  output logic [4:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_negative
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_VECTORS - 1);
  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  idx, settle_cnt, load_idx;
  logic        load_vec, accept, sample, mismatch;
  logic [68:0] stim;
  logic [33:0] exp_v;

  // {SrcA, SrcB, ALUControl}
  function automatic logic [68:0] rom_stim(input logic [3:0] i);
    case (i)
      4'd0:    rom_stim = {32'h000000F0, 32'h00000004, 5'b00000};
      4'd1:    rom_stim = {32'h0000000F, 32'h00000004, 5'b10000};
      4'd2:    rom_stim = {32'hFFFFFFFF, 32'h00000001, 5'b01001};
      4'd3:    rom_stim = {32'h00000005, 32'h00000002, 5'b01001};
      4'd4:    rom_stim = {32'h00000007, 32'h00000003, 5'b00010};
      4'd5:    rom_stim = {32'h00000005, 32'h00000008, 5'b01010};
      4'd6:    rom_stim = {32'h00000008, 32'h00000005, 5'b01010};
      4'd7:    rom_stim = {32'hFF00FF00, 32'h0F0F0F0F, 5'b00011};
      4'd8:    rom_stim = {32'hF0F0F0F0, 32'h0F0F0FF0, 5'b00111};
      4'd9:    rom_stim = {32'h00000010, 32'h00000010, 5'b01010};
      default: rom_stim = '0;
    endcase
  endfunction

  // {ALUResult, Zero, Negative}
  function automatic logic [33:0] rom_expect(input logic [3:0] i);
    case (i)
      4'd0:    rom_expect = {32'h00000F00, 1'b0, 1'b0};
      4'd1:    rom_expect = {32'h00000000, 1'b1, 1'b0};
      4'd2:    rom_expect = {32'h00000001, 1'b0, 1'b0};
      4'd3:    rom_expect = {32'h00000000, 1'b1, 1'b0};
      4'd4:    rom_expect = {32'h0000000A, 1'b0, 1'b0};
      4'd5:    rom_expect = {32'hFFFFFFFD, 1'b0, 1'b1};
      4'd6:    rom_expect = {32'h00000003, 1'b0, 1'b0};
      4'd7:    rom_expect = {32'h0F000F00, 1'b0, 1'b0};
      4'd8:    rom_expect = {32'hFFFFFFF0, 1'b0, 1'b1};
      4'd9:    rom_expect = {32'h00000000, 1'b1, 1'b0};
      default: rom_expect = '0;
    endcase
  endfunction

  assign accept   = (state == IDLE || state == DONE) && start;
  assign sample   = (state == SETTLE) && (settle_cnt == LAST_CNT);
  assign exp_v    = rom_expect(idx);
  assign mismatch = {alu_result, alu_zero, alu_negative} != exp_v;
  assign stim     = rom_stim(load_idx);

  assign busy = (state == DRIVE) || (state == SETTLE);
  assign done = (state == DONE);
  assign pass = done && (fail_count == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_vec  = 1'b0;
    load_idx  = 4'd0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = DRIVE;
          load_vec  = 1'b1;
        end
      end
      DRIVE: state_nxt = SETTLE;
      SETTLE: begin
        if (sample) begin
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            state_nxt = DRIVE;
            load_vec  = 1'b1;
            load_idx  = idx + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are loaded only on entry to DRIVE, so they stay put through SETTLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= 4'd0;
      settle_cnt  <= 4'd0;
      fail_count  <= 4'd0;
      alu_src_a   <= 32'd0;
      alu_src_b   <= 32'd0;
      alu_control <= 5'd0;
    end else begin
      if (load_vec) begin
        idx <= load_idx;
        {alu_src_a, alu_src_b, alu_control} <= stim;
      end else if (state_nxt == DONE) begin
        {alu_src_a, alu_src_b, alu_control} <= '0;
      end
      settle_cnt <= (state == SETTLE && !sample) ? settle_cnt + 4'd1 : 4'd0;
      if (accept)
        fail_count <= 4'd0;
      else if (sample && mismatch)
        fail_count <= fail_count + 4'd1;
    end
  end

`ifdef ALU_BIST_ERRLOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      first_fail_idx <= 4'd0;
    else if (accept)
      first_fail_idx <= 4'd0;
    else if (sample && mismatch && fail_count == 4'd0)
      first_fail_idx <= idx;
  end
`else
  assign first_fail_idx = 4'd0;
`endif

endmodule

// File: tb/tb_alu_bist.sv
// tb/tb_alu_bist.sv - randomized self-checking bench for alu_bist (default and 4-vector/3-settle builds).
module tb_alu_bist;

`ifdef ALU_BIST_ERRLOG_EN
  localparam bit ERRLOG = 1'b1;
`else
  localparam bit ERRLOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int printed = 0;

  logic [9:0]  bad_mask = '0;
  logic [33:0] flip [10];

  logic [1:0]        busy_v, done_v, pass_v, z_v, n_v;
  logic [1:0][3:0]   fc_v, ff_v;
  logic [1:0][31:0]  a_v, b_v, r_v;
  logic [1:0][4:0]   c_v;

  alu_bist #(.NUM_VECTORS(10), .SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .fail_count(fc_v[0]), .first_fail_idx(ff_v[0]),
    .alu_src_a(a_v[0]), .alu_src_b(b_v[0]), .alu_control(c_v[0]),
    .alu_result(r_v[0]), .alu_zero(z_v[0]), .alu_negative(n_v[0])
  );

  alu_bist #(.NUM_VECTORS(4), .SETTLE_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .fail_count(fc_v[1]), .first_fail_idx(ff_v[1]),
    .alu_src_a(a_v[1]), .alu_src_b(b_v[1]), .alu_control(c_v[1]),
    .alu_result(r_v[1]), .alu_zero(z_v[1]), .alu_negative(n_v[1])
  );

  function automatic int nv(input int g);
    return (g == 0) ? 10 : 4;
  endfunction

  function automatic int per(input int g);
    return (g == 0) ? 2 : 4;
  endfunction

  // Behavioural RV32 ALU: {result, zero, negative}
  function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [4:0] c);
    logic [31:0] r;
    case (c[1:0])
      2'b00:   r = c[4] ? (a >> b[4:0]) : (a << b[4:0]);
      2'b01:   r = {31'b0, $signed(a) < $signed(b)};
      2'b10:   r = c[3] ? (a - b) : (a + b);
      default: r = c[2] ? (a | b) : (a & b);
    endcase
    return {r, r == 32'd0, r[31]};
  endfunction

  function automatic logic [68:0] tvec(input int k);
    case (k)
      0: return {32'h000000F0, 32'h00000004, 5'b00000};
      1: return {32'h0000000F, 32'h00000004, 5'b10000};
      2: return {32'hFFFFFFFF, 32'h00000001, 5'b01001};
      3: return {32'h00000005, 32'h00000002, 5'b01001};
      4: return {32'h00000007, 32'h00000003, 5'b00010};
      5: return {32'h00000005, 32'h00000008, 5'b01010};
      6: return {32'h00000008, 32'h00000005, 5'b01010};
      7: return {32'hFF00FF00, 32'h0F0F0F0F, 5'b00011};
      8: return {32'hF0F0F0F0, 32'h0F0F0FF0, 5'b00111};
      9: return {32'h00000010, 32'h00000010, 5'b01010};
      default: return '0;
    endcase
  endfunction

  function automatic int vec_id(input logic [68:0] v);
    for (int k = 0; k < 10; k++)
      if (tvec(k) == v) return k;
    return -1;
  endfunction

  function automatic bit [9:0] bad_set();
    bit [9:0] s;
    s = '0;
    for (int k = 0; k < 10; k++)
      s[k] = bad_mask[k] && (flip[k] != 34'd0);
    return s;
  endfunction

  // ALU seen by each DUT, with per-vector fault injection
  int          vid;
  logic [33:0] obs;
  always_comb begin
    vid = 0;
    obs = '0;
    r_v = '0;
    z_v = '0;
    n_v = '0;
    for (int g = 0; g < 2; g++) begin
      vid = vec_id({a_v[g], b_v[g], c_v[g]});
      obs = alu_ref(a_v[g], b_v[g], c_v[g]);
      if (vid >= 0 && bad_mask[vid]) obs = obs ^ flip[vid];
      {r_v[g], z_v[g], n_v[g]} = obs;
    end
  end

  // Run-level reference: time since accepted start, and the fault set latched at that start
  bit       running [2];
  bit       finished [2];
  int       t [2];
  bit [9:0] run_bad [2];
  always @(posedge clk or negedge rst_n) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        running[g]  <= 1'b0;
        finished[g] <= 1'b0;
        t[g]        <= 0;
        run_bad[g]  <= '0;
      end else if (!running[g]) begin
        if (start) begin
          running[g]  <= 1'b1;
          finished[g] <= 1'b0;
          t[g]        <= 0;
          run_bad[g]  <= bad_set();
        end
      end else begin
        if (t[g] + 1 >= nv(g) * per(g)) begin
          running[g]  <= 1'b0;
          finished[g] <= 1'b1;
        end
        t[g] <= t[g] + 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      int          kd;
      logic [3:0]  ef, eff;
      logic [68:0] ev;
      logic [79:0] want, got;
      kd  = running[g] ? t[g] / per(g) : (finished[g] ? nv(g) : 0);
      ef  = 4'd0;
      eff = 4'd0;
      for (int k = 9; k >= 0; k--)
        if (k < kd && run_bad[g][k]) begin
          ef  = ef + 4'd1;
          eff = 4'(k);
        end
      if (!ERRLOG) eff = 4'd0;
      ev   = running[g] ? tvec(t[g] / per(g)) : '0;
      want = {running[g], finished[g], finished[g] && ef == 4'd0, ef, eff, ev};
      got  = {busy_v[g], done_v[g], pass_v[g], fc_v[g], ff_v[g], a_v[g], b_v[g], c_v[g]};
      checks++;
      if (got !== want) begin
        failures++;
        if (printed < 30) begin
          printed++;
          $display("FAIL cycle_cmp cfg%0d t=%0t actual=%h required=%h", g, $time, got, want);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    start = 1'b0;
    while (done_v != 2'b11 && n < 120) begin
      tick(1);
      n++;
    end
    chk("wait_done", {62'd0, done_v}, 64'd3);
  endtask

  task automatic run_and_wait();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    for (int k = 0; k < 10; k++) flip[k] = '0;
    tick(3);
    chk("reset_busy", {62'd0, busy_v}, 64'd0);
    chk("reset_done", {62'd0, done_v}, 64'd0);
    chk("reset_src_a", {32'd0, a_v[0]}, 64'd0);
    rst_n = 1'b1;
    tick(1);

    // Clean run: edge 0 is the start edge
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("busy_after_start", {62'd0, busy_v}, 64'd3);
    tick(15);
    chk("small_done_e15", {63'd0, done_v[1]}, 64'd0);
    tick(1);
    chk("small_done_e16", {63'd0, done_v[1]}, 64'd1);
    tick(3);
    chk("done_e19", {63'd0, done_v[0]}, 64'd0);
    chk("busy_e19", {63'd0, busy_v[0]}, 64'd1);
    tick(1);
    chk("done_e20", {63'd0, done_v[0]}, 64'd1);
    chk("pass_e20", {63'd0, pass_v[0]}, 64'd1);
    chk("fc_clean", {60'd0, fc_v[0]}, 64'd0);

    // Result forced to 0 on vector 5
    bad_mask = 10'b00_0010_0000;
    flip[5]  = {32'hFFFFFFFD, 2'b00};
    run_and_wait();
    chk("v5_fc", {60'd0, fc_v[0]}, 64'd1);
    chk("v5_pass", {63'd0, pass_v[0]}, 64'd0);
    chk("v5_first", {60'd0, ff_v[0]}, ERRLOG ? 64'd5 : 64'd0);
    chk("v5_small_pass", {63'd0, pass_v[1]}, 64'd1);

    // Zero flipped on vectors 1 and 9
    bad_mask = 10'b10_0000_0010;
    flip[1]  = 34'b10;
    flip[9]  = 34'b10;
    run_and_wait();
    chk("z19_fc", {60'd0, fc_v[0]}, 64'd2);
    chk("z19_first", {60'd0, ff_v[0]}, ERRLOG ? 64'd1 : 64'd0);
    chk("z19_small_fc", {60'd0, fc_v[1]}, 64'd1);

    // start held high: one run, then restart out of DONE
    bad_mask = '0;
    start = 1'b1;
    tick(1);
    tick(20);
    chk("held_done_e20", {63'd0, done_v[0]}, 64'd1);
    tick(1);
    chk("held_done_e21", {63'd0, done_v[0]}, 64'd0);
    chk("held_busy_e21", {63'd0, busy_v[0]}, 64'd1);
    wait_done();

    // Reset in the middle of a run that already has a failure
    bad_mask = 10'b00_0000_0001;
    flip[0]  = 34'd1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
    chk("mid_src_a", {32'd0, a_v[0]}, 64'd5);
    chk("mid_fc", {60'd0, fc_v[0]}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {62'd0, busy_v}, 64'd0);
    chk("abort_done", {62'd0, done_v}, 64'd0);
    chk("abort_fc", {60'd0, fc_v[0]}, 64'd0);
    chk("abort_src", {27'd0, a_v[0][31:0], c_v[0]}, 64'd0);
    tick(1);
    rst_n = 1'b1;
    bad_mask = '0;
    tick(1);
    run_and_wait();
    chk("after_reset_pass", {62'd0, pass_v}, 64'd3);

    // Random fault sets with random start traffic
    for (int it = 0; it < 8; it++) begin
      bad_mask = 10'($urandom);
      for (int k = 0; k < 10; k++) flip[k] = 34'd1 << $urandom_range(0, 33);
      start = 1'b1;
      tick(1);
      for (int c = 0; c < 40; c++) begin
        start = ($urandom_range(0, 3) == 0);
        tick(1);
      end
      wait_done();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
